// File: rtl/aprsc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aprsc_pkg
// Purpose  : Shared constants and types for the APRSC job front-end:
//            register offsets, STATUS bit positions, job FSM states and
//            the job record carried through the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package aprsc_pkg;

  // Channel index width covers the largest supported channel count (32).
  localparam int CH_W     = 5;
  // Job records carry DQ at its widest supported size; narrower DQW uses the low bits.
  localparam int DQ_MAX_W = 32;

  // Register offsets within the decoded 16-bit address window
  localparam logic [15:0] OFS_STG_DQ   = 16'h0000;
  localparam logic [15:0] OFS_STG_TR   = 16'h0004;
  localparam logic [15:0] OFS_STG_RATE = 16'h0008;
  localparam logic [15:0] OFS_STG_CH   = 16'h000C;
  localparam logic [15:0] OFS_PUSH     = 16'h0010;
  localparam logic [15:0] OFS_STATUS   = 16'h0014;
  localparam logic [15:0] OFS_DONE     = 16'h0018;
  localparam logic [15:0] OFS_BANK     = 16'h0100;

  // STATUS bit positions
  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [DQ_MAX_W-1:0] dq;
    logic                tr;
    logic [1:0]          rate;
  } job_t;

endpackage
`default_nettype wire

// File: rtl/aprsc_job_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : aprsc_job_queue_if
// Purpose  : Wishbone classic slave bus bundle for the APRSC job front-end.
// Revision : 1.0 - initial release
// ============================================================================
interface aprsc_job_queue_if;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic        o_wb_err;

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err
  );

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface
`default_nettype wire

// File: rtl/aprsc_job_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aprsc_job_fifo
// Purpose  : Synchronous job FIFO of DEPTH entries (power of two). Pushes
//            into a full FIFO and pops from an empty one are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module aprsc_job_fifo
  import aprsc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  job_t                       din,
  input  logic                       pop,
  output job_t                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  job_t          mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/aprsc_job_queue.sv
`default_nettype none
// ============================================================================
// Module   : aprsc_job_queue
// Purpose  : Multi-channel job front-end for the APRSC core. Jobs staged over
//            Wishbone are queued, issued to the core one at a time over
//            REQ/ACK, and results land in a per-channel bank with DONE flags.
// Revision : 1.0 - initial release
// ============================================================================
module aprsc_job_queue
  import aprsc_pkg::*;
#(
  parameter int NCH   = 32,
  parameter int DEPTH = 8,
  parameter int DQW   = 16,
  parameter int SEW   = 15,
  parameter int SRW   = 16,
  parameter int A2PW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  aprsc_job_queue_if.slave wb,
  output logic             core_req,
  output logic [DQW-1:0]   core_dq,
  output logic             core_tr,
  output logic [1:0]       core_rate,
  input  logic             core_ack,
  input  logic [SEW-1:0]   core_se,
  input  logic [SRW-1:0]   core_sr,
  input  logic [A2PW-1:0]  core_a2p
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]     adr;
  logic            acc;
  logic            wr;
  logic            rd;
  logic [DQW-1:0]  stg_dq;
  logic            stg_tr;
  logic [1:0]      stg_rate;
  logic [31:0]     stg_ch;
  logic            ovf;
  state_t          state;
  job_t            job;
  job_t            push_job;
  job_t            head;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            capture;
  logic [NCH-1:0]  done;
  logic [NCH-1:0]  done_set;
  logic [NCH-1:0]  done_clr;
  logic [SEW-1:0]  se_bank  [NCH];
  logic [SRW-1:0]  sr_bank  [NCH];
  logic [A2PW-1:0] a2p_bank [NCH];
  logic [15:0]     bank_rel;
  logic [CH_W-1:0] bank_ch;
  logic            bank_hit;
  logic [31:0]     status;
  logic [31:0]     rdata;
  logic            unused_ok;

  // A new access is accepted only while ack is low, so a held strobe acks on alternate cycles.
  assign adr = wb.i_wb_adr[15:0];
  assign acc = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_ack;
  assign wr  = acc & wb.i_wb_we;
  assign rd  = acc & ~wb.i_wb_we;

  assign push    = wr && (adr == OFS_PUSH);
  assign pop     = (state == ST_IDLE) && !fifo_empty;
  assign capture = (state == ST_ISSUE) && core_req && core_ack;

  assign core_dq   = job.dq[DQW-1:0];
  assign core_tr   = job.tr;
  assign core_rate = job.rate;

  assign wb.o_wb_err = 1'b0;
  assign unused_ok   = ^{wb.i_wb_sel, wb.i_wb_adr[31:16], job.dq, bank_rel};

  // Assemble the job record from the staging registers; channel folded into range.
  always_comb begin
    push_job      = '0;
    push_job.ch   = CH_W'(stg_ch % 32'(NCH));
    push_job.dq   = DQ_MAX_W'(stg_dq);
    push_job.tr   = stg_tr;
    push_job.rate = stg_rate;
  end

  aprsc_job_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_job),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Job FSM: pop head into job registers, hold REQ until ACK, then wait for ACK release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      core_req <= 1'b0;
      job      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          core_req <= 1'b0;
          if (!fifo_empty) begin
            job   <= head;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (core_req && core_ack) begin
            core_req <= 1'b0;
            state    <= ST_RELEASE;
          end else begin
            core_req <= 1'b1;
          end
        end
        ST_RELEASE: begin
          core_req <= 1'b0;
          if (!core_ack) state <= ST_IDLE;
        end
        default: begin
          core_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Staging registers and sticky overflow; a drop on the same edge as a clear keeps overflow set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stg_dq   <= '0;
      stg_tr   <= 1'b0;
      stg_rate <= '0;
      stg_ch   <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr) begin
        case (adr)
          OFS_STG_DQ:   stg_dq   <= wb.i_wb_dat[DQW-1:0];
          OFS_STG_TR:   stg_tr   <= wb.i_wb_dat[0];
          OFS_STG_RATE: stg_rate <= wb.i_wb_dat[1:0];
          OFS_STG_CH:   stg_ch   <= wb.i_wb_dat;
          default:      ;
        endcase
      end
      if (wr && (adr == OFS_STATUS) && wb.i_wb_dat[STAT_OVF]) ovf <= 1'b0;
      if (push && fifo_full) ovf <= 1'b1;
    end
  end

  assign done_set = capture ? (NCH'(1) << job.ch) : '0;
  assign done_clr = (wr && (adr == OFS_DONE)) ? wb.i_wb_dat[NCH-1:0] : '0;

  // DONE flags: completion set takes priority over a software clear of the same bit.
  always_ff @(posedge clk) begin
    if (!reset) done <= '0;
    else        done <= (done & ~done_clr) | done_set;
  end

  // Result bank written with the core outputs on the capture edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        se_bank[i]  <= '0;
        sr_bank[i]  <= '0;
        a2p_bank[i] <= '0;
      end
    end else if (capture) begin
      se_bank[job.ch]  <= core_se;
      sr_bank[job.ch]  <= core_sr;
      a2p_bank[job.ch] <= core_a2p;
    end
  end

  assign bank_rel = adr - OFS_BANK;
  assign bank_ch  = bank_rel[4 +: CH_W];
  assign bank_hit = (adr >= OFS_BANK) && ({4'b0, bank_rel[15:4]} < 16'(NCH));

  // STATUS word assembly.
  always_comb begin
    status                        = '0;
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_FULL]             = fifo_full;
    status[STAT_BUSY]             = (state != ST_IDLE);
    status[STAT_OVF]              = ovf;
    status[STAT_CNT_LSB +: 8]     = 8'(fifo_count);
  end

  // Read data mux; unmapped offsets read as zero.
  always_comb begin
    rdata = '0;
    if (bank_hit) begin
      case (bank_rel[3:0])
        4'h0:    rdata = 32'(se_bank[bank_ch]);
        4'h4:    rdata = 32'(sr_bank[bank_ch]);
        4'h8:    rdata = 32'(a2p_bank[bank_ch]);
        default: rdata = '0;
      endcase
    end else begin
      case (adr)
        OFS_STG_DQ:   rdata = 32'(stg_dq);
        OFS_STG_TR:   rdata = 32'(stg_tr);
        OFS_STG_RATE: rdata = 32'(stg_rate);
        OFS_STG_CH:   rdata = stg_ch;
        OFS_STATUS:   rdata = status;
        OFS_DONE:     rdata = 32'(done);
        default:      rdata = '0;
      endcase
    end
  end

  // Registered Wishbone ack pulse and read data, held until the next read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_dat <= '0;
    end else begin
      wb.o_wb_ack <= wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_ack;
      if (rd) wb.o_wb_dat <= rdata;
    end
  end

endmodule
`default_nettype wire
